// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the datapath sequencer (master) and the ALU execution unit (slave).
interface alu_exec_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [7:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] rout;
    logic        out_wb;
    logic        op_err;
    logic [4:0]  psr;

    modport master (
        output in_valid, r1, r2, opcode, out_ready,
        input  in_ready, out_valid, rout, out_wb, op_err, psr
    );

    modport slave (
        input  in_valid, r1, r2, opcode, out_ready,
        output in_ready, out_valid, rout, out_wb, op_err, psr
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ops respond at the acceptance edge, MUL 16 edges later (shift-add).
// Response is held until out_ready; a new request is taken in the same cycle the held response drains.
module alu_exec_unit (
    input  logic          clock,
    input  logic          reset_n,
    alu_exec_unit_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;
    typedef struct packed { logic n; logic z; logic f; logic l; logic c; } psr_t;

    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDU = 8'h06;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_SUBC = 8'h0A;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_MUL  = 8'h0E;
    localparam logic [7:0] OP_LSH  = 8'h84;
    localparam logic [7:0] OP_ASHU = 8'h86;

    state_t      r_state;
    logic        r_vld;
    logic [3:0]  r_cnt;
    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [15:0] r_mplier;
    logic [15:0] r_rout;
    logic        r_wb;
    logic        r_err;
    psr_t        r_psr;

    logic        w_accept;
    logic        w_cin;
    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic        w_shneg;
    logic [4:0]  w_shamt;
    logic [15:0] w_res;
    logic        w_wb;
    logic        w_err;
    psr_t        w_psr;
    logic [15:0] w_acc_nxt;

    assign bus.in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = r_vld;
    assign bus.rout      = r_rout;
    assign bus.out_wb    = r_wb;
    assign bus.op_err    = r_err;
    assign bus.psr       = r_psr;

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_cin   = ((bus.opcode == OP_ADDC) || (bus.opcode == OP_SUBC)) ? r_psr.c : 1'b0;
        w_sum   = {1'b0, bus.r1} + {1'b0, bus.r2} + {16'd0, w_cin};
        w_diff  = {1'b0, bus.r1} - {1'b0, bus.r2} - {16'd0, w_cin};
        // r2[4:0] is a signed amount; magnitude 16 is reachable only as a right shift
        w_shneg = bus.r2[4];
        w_shamt = w_shneg ? (~bus.r2[4:0] + 5'd1) : bus.r2[4:0];
        w_res   = r_rout;
        w_wb    = 1'b1;
        w_err   = 1'b0;
        w_psr   = r_psr;
        case (bus.opcode)
            OP_ADD, OP_ADDC: begin
                w_res   = w_sum[15:0];
                w_psr.c = w_sum[16];
                w_psr.f = (bus.r1[15] == bus.r2[15]) && (w_sum[15] != bus.r1[15]);
            end
            OP_ADDU: w_res = w_sum[15:0];
            OP_SUB, OP_SUBC: begin
                w_res   = w_diff[15:0];
                w_psr.c = w_diff[16];
                w_psr.f = (bus.r1[15] != bus.r2[15]) && (w_diff[15] != bus.r1[15]);
            end
            OP_CMP: begin
                w_wb    = 1'b0;
                w_psr.z = (bus.r1 == bus.r2);
                w_psr.l = (bus.r1 < bus.r2);
                w_psr.n = ($signed(bus.r1) < $signed(bus.r2));
            end
            OP_AND:  w_res = bus.r1 & bus.r2;
            OP_OR:   w_res = bus.r1 | bus.r2;
            OP_XOR:  w_res = bus.r1 ^ bus.r2;
            OP_MUL:  w_res = r_rout;
            OP_LSH:  w_res = w_shneg ? (bus.r1 >> w_shamt) : (bus.r1 << w_shamt);
            OP_ASHU: w_res = w_shneg ? $unsigned($signed(bus.r1) >>> w_shamt) : (bus.r1 << w_shamt);
            default: begin
                w_res = 16'd0;
                w_wb  = 1'b0;
                w_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_vld    <= 1'b0;
            r_cnt    <= 4'd0;
            r_acc    <= 16'd0;
            r_mcand  <= 16'd0;
            r_mplier <= 16'd0;
            r_rout   <= 16'd0;
            r_wb     <= 1'b0;
            r_err    <= 1'b0;
            r_psr    <= '0;
        end else begin
            case (r_state)
                ST_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_rout  <= w_acc_nxt;
                        r_state <= ST_DONE;
                        r_vld   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready && !w_accept) begin
                        r_state <= ST_IDLE;
                        r_vld   <= 1'b0;
                    end
                end
                default: ;
            endcase
            // Acceptance overrides the DONE->IDLE drain so back-to-back ops have no bubble
            if (w_accept) begin
                r_wb  <= w_wb;
                r_err <= w_err;
                r_psr <= w_psr;
                if (bus.opcode == OP_MUL) begin
                    r_state  <= ST_MUL;
                    r_vld    <= 1'b0;
                    r_cnt    <= 4'd0;
                    r_acc    <= 16'd0;
                    r_mcand  <= bus.r1;
                    r_mplier <= bus.r2;
                end else begin
                    r_rout  <= w_res;
                    r_state <= ST_DONE;
                    r_vld   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench: driver pushes model predictions on acceptance, monitor pops on each response handshake.
module tb_alu_exec_unit;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    alu_exec_unit_if bus();
    alu_exec_unit dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic [15:0] rout;
        logic        wb;
        logic        err;
        logic [4:0]  psr;
        int          cyc;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    logic mN, mZ, mF, mL, mC;
    logic [15:0] m_last;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit seen = 0;
    int rdy_mode = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        {mN, mZ, mF, mL, mC} = 5'b0;
        m_last = 16'h0;
    endtask

    // Reference model: integer arithmetic on the operation definitions
    task automatic model_accept(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b, input int acc_cyc);
        int unsigned ua, ub, cin, full;
        int sa, sb, s, sh;
        logic [15:0] res;
        logic wb, err;
        exp_t e;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        cin = ((op == 8'h07) || (op == 8'h0A)) ? int'(mC) : 0;
        wb = 1'b1; err = 1'b0; res = 16'h0;
        case (op)
            8'h05, 8'h07: begin
                full = ua + ub + cin; res = 16'(full);
                mC = (full > 65535);
                s = sa + sb + int'(cin); mF = (s > 32767) || (s < -32768);
            end
            8'h06: res = 16'(ua + ub);
            8'h09, 8'h0A: begin
                res = 16'(ua - ub - cin);
                mC = (ua < ub + cin);
                s = sa - sb - int'(cin); mF = (s > 32767) || (s < -32768);
            end
            8'h0B: begin
                wb = 1'b0; res = m_last;
                mZ = (ua == ub); mL = (ua < ub); mN = (sa < sb);
            end
            8'h01: res = a & b;
            8'h02: res = a | b;
            8'h03: res = a ^ b;
            8'h0E: res = 16'(ua * ub);
            8'h84, 8'h86: begin
                sh = int'(ub & 31);
                if (sh >= 16) sh = sh - 32;
                if (sh >= 0) res = 16'(ua << sh);
                else if (op == 8'h84) res = 16'(ua >> (-sh));
                else begin s = sa >>> (-sh); res = 16'(s); end
            end
            default: begin res = 16'h0; wb = 1'b0; err = 1'b1; end
        endcase
        m_last = res;
        e.rout = res; e.wb = wb; e.err = err; e.psr = {mN, mZ, mF, mL, mC};
        e.cyc = acc_cyc + ((op == 8'h0E) ? 16 : 0);
        expq.push_back(e);
    endtask

    // Call at posedge+1; returns at posedge+1 after the acceptance edge
    task automatic issue(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1; bus.opcode = op; bus.r1 = a; bus.r2 = b;
        for (int w = 0; w < 200 && !ok; w++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                model_accept(op, a, b, cyc + 1);
                ok = 1;
            end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        bus.opcode = 8'($urandom); bus.r1 = 16'($urandom); bus.r2 = 16'($urandom);
    endtask

    task automatic drain();
        for (int w = 0; w < 2000 && expq.size() != 0; w++) @(negedge clock);
        chk("drain_empty", expq.size(), 0);
        @(posedge clock); #1;
    endtask

    always @(negedge clock) begin
        if (reset_n && bus.out_valid) begin
            if (expq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_resp: got out_valid=1 expected 0 (rout=0x%0h)", bus.rout);
            end else begin
                mon_e = expq[0];
                if (!seen) begin
                    seen = 1;
                    chk("resp_cycle", cyc, mon_e.cyc);
                end
                if (bus.out_ready) begin
                    chk("rout", bus.rout, mon_e.rout);
                    chk("out_wb", bus.out_wb, mon_e.wb);
                    chk("op_err", bus.op_err, mon_e.err);
                    chk("psr", bus.psr, mon_e.psr);
                    void'(expq.pop_front());
                    seen = 0;
                end
            end
        end
    end

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    logic [7:0] ops [13] = '{8'h05, 8'h06, 8'h07, 8'h09, 8'h0A, 8'h0B, 8'h01,
                             8'h02, 8'h03, 8'h0E, 8'h84, 8'h86, 8'h00};
    bit any_vld;
    logic [7:0] rop;

    initial begin
        bus.in_valid = 1'b0; bus.r1 = 16'h0; bus.r2 = 16'h0; bus.opcode = 8'h0;
        reset_model();
        repeat (3) @(negedge clock);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_rout", bus.rout, 0);
        chk("rst_out_wb", bus.out_wb, 0);
        chk("rst_op_err", bus.op_err, 0);
        chk("rst_psr", bus.psr, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        rdy_mode = 0;
        issue(8'h05, 16'h7FFF, 16'h0001);
        issue(8'h05, 16'hFFFF, 16'h0001);
        issue(8'h05, 16'hFFFF, 16'h0001);
        issue(8'h07, 16'h0001, 16'h0001);
        issue(8'h09, 16'h0001, 16'h0002);
        issue(8'h0B, 16'h0005, 16'h0005);
        issue(8'h0E, 16'h0003, 16'h0005);
        issue(8'h0E, 16'h1234, 16'h0100);
        issue(8'h84, 16'h8001, 16'h0001);
        issue(8'h84, 16'h8000, 16'h0011);
        issue(8'h86, 16'h8000, 16'h0011);
        issue(8'h86, 16'h8000, 16'h0010);
        drain();

        // Illegal opcode held with out_ready low while another request waits
        rdy_mode = 2;
        @(posedge clock); #1;
        issue(8'h55, 16'h1357, 16'h2468);
        bus.in_valid = 1'b1; bus.opcode = 8'h05; bus.r1 = 16'h0001; bus.r2 = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_rout", bus.rout, 0);
            chk("hold_op_err", bus.op_err, 1);
            chk("hold_out_wb", bus.out_wb, 0);
            chk("hold_psr", bus.psr, {mN, mZ, mF, mL, mC});
        end
        bus.in_valid = 1'b0;
        rdy_mode = 0;
        drain();

        // Reset in the middle of a multiply
        issue(8'h0E, 16'h1234, 16'h00FF);
        repeat (5) @(posedge clock);
        #1;
        reset_n = 1'b0;
        expq.delete();
        seen = 0;
        reset_model();
        @(negedge clock);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_rout", bus.rout, 0);
        chk("abort_out_wb", bus.out_wb, 0);
        chk("abort_op_err", bus.op_err, 0);
        chk("abort_psr", bus.psr, 0);
        @(negedge clock);
        reset_n = 1'b1;
        any_vld = 0;
        repeat (20) begin
            @(negedge clock);
            if (bus.out_valid) any_vld = 1;
        end
        chk("abort_no_resp", any_vld, 0);
        @(posedge clock); #1;

        rdy_mode = 1;
        for (int n = 0; n < 300; n++) begin
            rop = ops[$urandom_range(0, 12)];
            if (rop == 8'h00) rop = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clock);
                #1;
            end
            issue(rop, pick(), pick());
        end
        rdy_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
